// File: rtl/matrix_reader.sv
// rtl/matrix_reader.sv - row-major stream loader that fills n x n matrix storage and keeps a checksum
module matrix_reader #(
    parameter int n  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [31:0]   value,
    output logic          busy,
    output logic          done,
    output logic [31:0]   checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(n - 1);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          accept;
    logic          last_elem;

    assign accept    = in_valid & in_ready;
    assign last_elem = accept && (row == LAST) && (col == LAST);

    // State register; reset overrides any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: if (last_elem) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are pure state decodes, so in_ready never depends on in_valid.
    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
    end

    // Counters, registered write port and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            wr_en    <= 1'b0;
            i        <= '0;
            j        <= '0;
            value    <= '0;
            checksum <= '0;
        end else begin
            wr_en <= accept;
            if (state == S_IDLE && start) begin
                row      <= '0;
                col      <= '0;
                checksum <= '0;
            end
            if (accept) begin
                i        <= row;
                j        <= col;
                value    <= in_data;
                checksum <= checksum + in_data;
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_reader.sv
// tb/tb_matrix_reader.sv - randomized self-checking bench for matrix_reader
module tb_matrix_reader;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [31:0]   value;
    logic          busy;
    logic          done;
    logic [31:0]   checksum;

    matrix_reader #(.n(N), .IW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
        .i(i), .j(j), .value(value), .busy(busy), .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Words to present in row-major order, and what the storage port actually received.
    logic [31:0] stim_q[$];
    int          obs_i[$];
    int          obs_j[$];
    logic [31:0] obs_v[$];
    int          done_count;
    int          done_with_wr;
    int          accept_cycles;
    int          gap_wr;
    int          busy_after;
    logic [31:0] chk_at_done;

    // Model: word k of a load lands at (k / n, k % n).
    function automatic int write_errors();
        int e = 0;
        if (obs_i.size() != N * N || obs_v.size() != N * N) return 1000;
        for (int k = 0; k < N * N; k++) begin
            if (obs_i[k] != k / N || obs_j[k] != k % N || obs_v[k] !== stim_q[k]) e++;
        end
        return e;
    endfunction

    function automatic logic [31:0] model_sum();
        logic [31:0] s = 32'd0;
        foreach (stim_q[k]) s = s + stim_q[k];
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams stim_q from LOAD; records writes and ends one cycle after done.
    // gap_mode 0: continuous, 1: valid every other cycle, 2: random valid.
    task automatic drive_load(input int gap_mode, input int start_pulse_at);
        int idx = 0;
        int cyc = 0;
        bit fin = 0;
        bit seen_done = 0;
        bit v;
        bit took;
        obs_i.delete(); obs_j.delete(); obs_v.delete();
        done_count = 0; done_with_wr = 0; accept_cycles = 0; gap_wr = 0;
        busy_after = -1; chk_at_done = 32'hx;
        while (!fin && cyc < 300) begin
            case (gap_mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (idx >= stim_q.size()) v = 1'b0;
            in_valid = v;
            in_data  = v ? stim_q[idx] : $urandom;
            start    = (cyc == start_pulse_at);
            took     = v && in_ready;
            if (in_ready) accept_cycles++;
            @(posedge clk); #1;
            cyc++;
            if (took) idx++;
            if (wr_en) begin
                obs_i.push_back(int'(i));
                obs_j.push_back(int'(j));
                obs_v.push_back(value);
                if (!took) gap_wr++;
            end
            if (seen_done) begin
                busy_after = int'(busy);
                if (done) done_count++;
                fin = 1;
            end else if (done) begin
                done_count++;
                done_with_wr = int'(wr_en);
                chk_at_done  = checksum;
                seen_done    = 1;
            end
        end
        start = 1'b0; in_valid = 1'b0;
        if (!fin) begin
            tests++; fails++;
            $display("FAIL load_timeout: done not seen within 300 cycles, accepted=%0d required=%0d", idx, stim_q.size());
        end
    endtask

    task automatic fill_seq(input logic [31:0] first);
        stim_q.delete();
        for (int k = 0; k < N * N; k++) stim_q.push_back(first + 32'(k));
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if ({wr_en, done, busy, in_ready} !== 4'b0) begin fails++;
            $display("FAIL reset_flags: got %b required 0000", {wr_en, done, busy, in_ready}); end
        tests++; if ({i, j} !== '0) begin fails++;
            $display("FAIL reset_index: got i=%0d j=%0d required 0,0", i, j); end
        tests++; if (value !== 32'd0) begin fails++;
            $display("FAIL reset_value: got %h required 0", value); end
        tests++; if (checksum !== 32'd0) begin fails++;
            $display("FAIL reset_checksum: got %h required 0", checksum); end
    endtask

    task automatic test_basic_load();
        fill_seq(32'd1);
        do_start();
        tests++; if ({busy, in_ready} !== 2'b11) begin fails++;
            $display("FAIL start_latency: busy,in_ready=%b required 11", {busy, in_ready}); end
        drive_load(0, -1);
        tests++; if (write_errors() != 0) begin fails++;
            $display("FAIL basic_writes: %0d bad writes of %0d observed, required 0", write_errors(), obs_v.size()); end
        tests++; if (done_count != 1 || done_with_wr != 1) begin fails++;
            $display("FAIL basic_done: pulses=%0d with_wr=%0d required 1,1", done_count, done_with_wr); end
        tests++; if (chk_at_done !== model_sum() || chk_at_done !== 32'd136) begin fails++;
            $display("FAIL basic_checksum: got %0d required 136", chk_at_done); end
        tests++; if (accept_cycles != N * N || busy_after != 0) begin fails++;
            $display("FAIL basic_timing: load_cycles=%0d busy_after=%0d required %0d,0", accept_cycles, busy_after, N * N); end
        tests++; if (wr_en !== 1'b0 || i !== IW'(N - 1) || j !== IW'(N - 1) || value !== 32'd16) begin fails++;
            $display("FAIL basic_hold: wr_en=%b i=%0d j=%0d value=%0d required 0,3,3,16", wr_en, i, j, value); end
    endtask

    task automatic test_gapped();
        fill_seq(32'd1);
        do_start();
        drive_load(1, -1);
        tests++; if (write_errors() != 0 || gap_wr != 0) begin fails++;
            $display("FAIL gapped_writes: bad=%0d gap_writes=%0d required 0,0", write_errors(), gap_wr); end
        tests++; if (accept_cycles != 2 * N * N - 1) begin fails++;
            $display("FAIL gapped_cycles: got %0d required %0d", accept_cycles, 2 * N * N - 1); end
        tests++; if (done_count != 1 || chk_at_done !== 32'd136) begin fails++;
            $display("FAIL gapped_done: pulses=%0d checksum=%0d required 1,136", done_count, chk_at_done); end
    endtask

    task automatic test_guards();
        int bad = 0;
        do_reset();
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            if (in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            if (wr_en !== 1'b0 || checksum !== 32'd0 || busy !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        tests++; if (bad != 0) begin fails++;
            $display("FAIL idle_valid_ignored: %0d bad cycles, required 0 (checksum=%h)", bad, checksum); end
        stim_q.delete();
        for (int k = 0; k < N * N; k++) stim_q.push_back($urandom);
        do_start();
        drive_load(0, 5);
        tests++; if (write_errors() != 0 || chk_at_done !== model_sum()) begin fails++;
            $display("FAIL midload_start: bad=%0d checksum=%h required 0,%h", write_errors(), chk_at_done, model_sum()); end
    endtask

    task automatic test_reset_mid_load();
        do_start();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 32'd500 + 32'(k);
            @(posedge clk); #1;
        end
        rst = 1'b1; in_data = 32'd999;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        tests++; if ({wr_en, done, busy, in_ready, i, j} !== '0 || value !== 32'd0 || checksum !== 32'd0) begin fails++;
            $display("FAIL midload_reset: flags=%b i=%0d j=%0d value=%h checksum=%h required all 0",
                     {wr_en, done, busy, in_ready}, i, j, value, checksum); end
        fill_seq(32'd100);
        do_start();
        drive_load(0, -1);
        tests++; if (write_errors() != 0) begin fails++;
            $display("FAIL reload_writes: %0d bad writes, required 0", write_errors()); end
        tests++; if (chk_at_done !== 32'd1720 || chk_at_done !== model_sum()) begin fails++;
            $display("FAIL reload_checksum: got %0d required 1720", chk_at_done); end
    endtask

    task automatic test_back_to_back();
        fill_seq(32'd1);
        do_start();
        drive_load(0, -1);
        tests++; if (done_count != 1 || busy_after != 0) begin fails++;
            $display("FAIL b2b_first: pulses=%0d busy_after=%0d required 1,0", done_count, busy_after); end
        stim_q.delete();
        for (int k = 0; k < N * N; k++) stim_q.push_back(32'hFFFFFFFF);
        do_start();
        drive_load(0, -1);
        tests++; if (write_errors() != 0) begin fails++;
            $display("FAIL b2b_writes: %0d bad writes, required 0", write_errors()); end
        tests++; if (chk_at_done !== 32'hFFFFFFF0 || chk_at_done !== model_sum()) begin fails++;
            $display("FAIL b2b_checksum: got %h required fffffff0", chk_at_done); end
        tests++; if (done_count != 1) begin fails++;
            $display("FAIL b2b_done: pulses=%0d required 1", done_count); end
    endtask

    task automatic test_reset_and_start();
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        tests++; if ({busy, in_ready, done} !== 3'b000) begin fails++;
            $display("FAIL reset_wins: busy,in_ready,done=%b required 000", {busy, in_ready, done}); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++;
            $display("FAIL reset_wins_hold: busy=%b required 0", busy); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            stim_q.delete();
            for (int k = 0; k < N * N; k++) stim_q.push_back($urandom);
            do_start();
            drive_load(2, -1);
            tests++; if (write_errors() != 0 || gap_wr != 0) begin fails++;
                $display("FAIL random_writes[%0d]: bad=%0d gap_writes=%0d required 0,0", r, write_errors(), gap_wr); end
            tests++; if (done_count != 1 || chk_at_done !== model_sum()) begin fails++;
                $display("FAIL random_done[%0d]: pulses=%0d checksum=%h required 1,%h", r, done_count, chk_at_done, model_sum()); end
            repeat (3) @(posedge clk);
            #1;
            tests++; if (checksum !== model_sum() || busy !== 1'b0) begin fails++;
                $display("FAIL random_idle_hold[%0d]: checksum=%h busy=%b required %h,0", r, checksum, busy, model_sum()); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        test_reset();
        test_basic_load();
        test_gapped();
        test_guards();
        test_reset_mid_load();
        test_back_to_back();
        test_reset_and_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_reader.md
# matrix_reader

Loading counterpart to the matrix file writer. The writer walks an n×n matrix by (i, j) and emits each element. This block runs the other way: it accepts a row-major stream of 32-bit words over a valid/ready handshake and drives registered (i, j, value, write-enable) to fill the matrix storage. It asserts `done` once all n×n elements are written, and reports a running checksum of the loaded words.

## Interface
- `n`, 4, matrix dimension (n ≥ 2); n×n elements per load.
- `IW`, 2, index width; must equal ceil(log2(n)).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `in_data`  in  32  stream word, row-major order.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_ready`  out  1  block accepts a word this cycle.
- `wr_en`  out  1  write strobe to matrix storage.
- `i`  out  IW  row index of the write.
- `j`  out  IW  column index of the write.
- `value`  out  32  data to write at (i, j).
- `busy`  out  1  high when state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the load is complete.
- `checksum`  out  32  sum mod 2^32 of words accepted in the current or last load.

## Operation
- States: IDLE, LOAD, DONE.
- **IDLE**
  - `in_ready` = 0.
  - `start` = 1 → LOAD: clear row/col counters to 0 and clear `checksum`.
- **LOAD**
  - `in_ready` = 1, decoded combinationally from state.
  - Accept occurs when `in_valid` & `in_ready`.
  - On accept, the next cycle drives `wr_en` = 1, `i`/`j` = current counters, `value` = `in_data`, and `checksum` += `in_data`.
  - Counter advance on accept: col = col+1. When col = n−1, col wraps to 0 and row = row+1.
  - If the accept is at row = n−1, col = n−1 → DONE. Counters wrap to 0.
  - Cycles with `in_valid` = 0 write nothing. Counters and `checksum` hold.
- **DONE**
  - `done` = 1 and `in_ready` = 0 for exactly one cycle, then → IDLE.
- `start` is ignored in LOAD and DONE.
- `start` asserted in IDLE during the cycle right after DONE begins a new load.
- `in_valid` outside LOAD is ignored. No word is consumed and `checksum` is unchanged.
- `checksum` holds its final value in IDLE until the next `start`.
- `i`, `j` and `value` hold their last written values when `wr_en` = 0. Storage must qualify on `wr_en` only.
- **Reset**
  - `rst` forces IDLE regardless of state, including mid-LOAD.
  - Counters, `i`, `j` and `value` → 0. `wr_en`, `done`, `busy`, `in_ready` → 0. `checksum` → 0.
  - A partial load is abandoned. Already-written elements are not undone.
- Arithmetic:
  - `checksum` is a 32-bit wrap-around add. Overflow is discarded and no flag is raised.
  - Counters are IW bits wide and compare against n−1. They never index ≥ n.

## Timing
- Reset values of all outputs: 0.
- `start` sampled at edge T0 → LOAD in cycle T0+1. `busy` = 1 and `in_ready` = 1 from T0+1.
- Accept at edge T → `wr_en`/`i`/`j`/`value` valid in cycle T+1, and `checksum` updated in cycle T+1. Latency is 1 cycle.
- Throughput: one word per cycle with continuous `in_valid`. A full load takes n×n cycles of LOAD.
- Last accept at edge T:
  - DONE in cycle T+1: `done` = 1, `in_ready` = 0, and the final `wr_en` is in the same cycle.
  - `checksum` is final in cycle T+1.
  - IDLE in cycle T+2, with `busy` = 0.
- `in_ready` never depends combinationally on `in_valid`.
- `rst` and `start` asserted together: reset wins and the block stays in IDLE.

## Test plan
- **Basic load:** reset, `start`, then stream 1..16 continuously (n = 4). Expect:
  - 16 consecutive `wr_en` cycles, (0,0)=1, (0,3)=4, (1,0)=5 … (3,3)=16.
  - `done` pulses once, in the same cycle as the (3,3) write.
  - `checksum` = 136 and `busy` falls the next cycle.
- **Gapped stream:** drop `in_valid` every other cycle while streaming 1..16. Expect:
  - Identical (i, j, value) sequence to the basic load.
  - No `wr_en` during gap cycles.
  - `done` after 31 LOAD cycles, `checksum` = 136.
- **Protocol guards:**
  - Assert `in_valid` with 0xDEADBEEF before `start`. Expect `in_ready` = 0, no `wr_en`, `checksum` stays 0.
  - Pulse `start` mid-load. Expect no effect on the counters.
- **Reset mid-load:** reset after 5 accepted words. Expect:
  - All outputs 0 and IDLE next cycle.
  - A fresh `start` followed by stream 100..115 writes (0,0)=100 onward.
  - `checksum` = 1720.
- **Back-to-back with wrap:** second `start` in the cycle after `done`, streaming 16 words of 0xFFFFFFFF. Expect:
  - Second load begins at (0,0).
  - `checksum` = 0xFFFFFFF0 (mod 2^32).
  - Exactly one `done` pulse per load.
